program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction fetch path. The core only reads program memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into program memory at consecutive word addresses.
- Holds the core in reset until the whole image is loaded.

Parameters:
PROGRAM_MEMORY_DEPTH, 64, capacity of program memory in 32-bit words; upper limit on image length
BASE_ADDRESS, 32'h0040_0000, byte address of program word 0, the first address the core fetches after reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Start_i  input  1  request a new load; sampled only in IDLE, DONE or ERROR
Byte_Valid_i  input  1  Byte_Data_i is valid
Byte_Data_i  input  8  stream byte
Byte_Ready_o  output  1  loader can accept a byte this cycle
Mem_Write_o  output  1  one-cycle write strobe to program memory
Mem_Address_o  output  32  byte address of the word being written
Mem_Data_o  output  32  word being written
Core_Reset_o  output  1  active-low reset to the core; high only in DONE
Busy_o  output  1  high in LEN_LO, LEN_HI, DATA and WRITE
Done_o  output  1  high in DONE
Error_o  output  1  high in ERROR

Behaviour:
- Async reset (reset=0):
  - State goes to IDLE immediately; word counter, byte index and length cleared.
  - Outputs: Byte_Ready_o=0, Mem_Write_o=0, Mem_Address_o=BASE_ADDRESS, Mem_Data_o=0, Core_Reset_o=0, Busy_o=0, Done_o=0, Error_o=0.
  - Reset during a load aborts it. Any partial word is discarded and the core stays in reset.
- Byte transfer: a byte is accepted on a rising clk edge where Byte_Valid_i=1 and Byte_Ready_o=1. Byte_Ready_o is a registered state decode with no combinational path from Byte_Valid_i.
- Stream format:
  - Byte 0 = N[7:0], byte 1 = N[15:8]. N is the word count.
  - Then 4*N data bytes. Word bytes arrive LSB first: byte k of a word fills Mem_Data_o[8k+7:8k].
- States:
  - IDLE: Ready=0. Start_i=1 -> LEN_LO.
  - LEN_LO: Ready=1. On accept, latch N low byte -> LEN_HI.
  - LEN_HI: Ready=1. On accept, latch N high byte. Check the complete N:
    - N==0 or N>PROGRAM_MEMORY_DEPTH -> ERROR.
    - Otherwise -> DATA, with word index=0 and byte index=0.
  - DATA: Ready=1. Each accepted byte goes into the assembly register at the byte index; the index increments mod 4. On the 4th byte -> WRITE.
  - WRITE (exactly one cycle): Ready=0, Mem_Write_o=1, Mem_Data_o=assembled word, Mem_Address_o=BASE_ADDRESS + 4*word_index (32-bit add).
    - Next edge: word_index+1.
    - word_index+1==N -> DONE; else -> DATA.
  - DONE: Core_Reset_o=1, Done_o=1, Ready=0. Start_i=1 -> LEN_LO; Core_Reset_o drops to 0 the same edge.
  - ERROR: Error_o=1, Core_Reset_o=0, Ready=0. Start_i=1 -> LEN_LO and clears Error_o.
- Latency and timing:
  - Minimum load time is 2+5N cycles from the first accepted byte to entering DONE.
  - Mem_Address_o and Mem_Data_o are registered and stable for the whole Mem_Write_o pulse.
  - Outside WRITE, Mem_Write_o=0. Address and data hold their last values; memory must ignore them.
- Boundary cases:
  - Start_i while Busy_o=1 is ignored.
  - Byte_Valid_i while Ready=0 is ignored, not buffered. The source must hold the byte.
  - N==PROGRAM_MEMORY_DEPTH is legal; the last address is BASE_ADDRESS + 4*(DEPTH-1).
  - The word index is wide enough for DEPTH and never wraps inside a legal load.
  - Gaps in Byte_Valid_i simply stall the state machine. There is no timeout.

Test Plan:
1. Reset low mid-stream, then release -> all outputs at reset values, state IDLE, Core_Reset_o=0, no Mem_Write_o pulse.
2. Start_i pulse, bytes 02 00 13 05 A0 00 93 05 B0 00, Valid held high -> writes 0x00A00513 @0x00400000, then 0x00B00593 @0x00400004. Each Mem_Write_o is one cycle with Ready=0 that cycle. DONE with Core_Reset_o=1 at cycle 12 after the first accept.
3. Same stream with Byte_Valid_i toggling 1,0,1,0 -> identical writes and data, load time stretched, no byte lost or duplicated.
4. Length 00 00, then length 41 00 with DEPTH=64 -> ERROR, Error_o=1, no writes, Core_Reset_o=0. Start_i then a valid length 40 00 with 256 bytes -> 64 writes, last address 0x004000FC, DONE.
5. Start_i asserted during DATA -> ignored, load completes normally. Start_i in DONE -> Core_Reset_o falls on the same edge, Done_o=0, a new load begins at address 0x00400000.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte stream in, program memory write port out.
// The loader binds to the slave modport; the byte source binds to master.
interface program_loader_if;
    logic        Byte_Valid_i;
    logic [7:0]  Byte_Data_i;
    logic        Byte_Ready_o;
    logic        Mem_Write_o;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Data_o;

    modport master (
        output Byte_Valid_i,
        output Byte_Data_i,
        input  Byte_Ready_o,
        input  Mem_Write_o,
        input  Mem_Address_o,
        input  Mem_Data_o
    );

    modport slave (
        input  Byte_Valid_i,
        input  Byte_Data_i,
        output Byte_Ready_o,
        output Mem_Write_o,
        output Mem_Address_o,
        output Mem_Data_o
    );
endinterface

// File: rtl/program_loader.sv
// Fills program memory from a length-prefixed byte stream and
// holds the core in reset until the whole image is written.
module program_loader #(
    parameter int          PROGRAM_MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDRESS         = 32'h0040_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start_i,
    program_loader_if.slave  bus,
    output logic             Core_Reset_o,
    output logic             Busy_o,
    output logic             Done_o,
    output logic             Error_o
);
    localparam int IDX_W = $clog2(PROGRAM_MEMORY_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [15:0]        len;
    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         byte_idx;
    logic [23:0]        asm_word;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_data;
    logic               accept;
    logic [15:0]        len_full;
    logic [16:0]        idx_inc;
    logic               len_bad;

    assign accept   = bus.Byte_Valid_i && bus.Byte_Ready_o;
    assign len_full = {bus.Byte_Data_i, len[7:0]};
    assign idx_inc  = 17'(word_idx) + 17'd1;
    assign len_bad  = (len_full == 16'd0) ||
                      (len_full > 16'(PROGRAM_MEMORY_DEPTH));

    // Every output is a decode of the state register or a register.
    assign bus.Byte_Ready_o  = (state == LEN_LO) ||
                               (state == LEN_HI) ||
                               (state == DATA);
    assign bus.Mem_Write_o   = (state == WRITE);
    assign bus.Mem_Address_o = mem_addr;
    assign bus.Mem_Data_o    = mem_data;
    assign Busy_o            = bus.Byte_Ready_o || (state == WRITE);
    assign Done_o            = (state == DONE);
    assign Core_Reset_o      = (state == DONE);
    assign Error_o           = (state == ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (Start_i) state_nx = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_nx = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_nx = len_bad ? ERROR : DATA;
            end
            DATA: begin
                if (accept && byte_idx == 2'd3) state_nx = WRITE;
            end
            WRITE: begin
                state_nx = (idx_inc == {1'b0, len}) ? DONE : DATA;
            end
            DONE, ERROR: begin
                if (Start_i) state_nx = LEN_LO;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            asm_word <= '0;
            mem_addr <= BASE_ADDRESS;
            mem_data <= '0;
        end else begin
            case (state)
                LEN_LO: begin
                    if (accept) len[7:0] <= bus.Byte_Data_i;
                end
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= bus.Byte_Data_i;
                        word_idx  <= '0;
                        byte_idx  <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        unique case (1'b1)
                            byte_idx == 2'd0: asm_word[7:0]   <= bus.Byte_Data_i;
                            byte_idx == 2'd1: asm_word[15:8]  <= bus.Byte_Data_i;
                            byte_idx == 2'd2: asm_word[23:16] <= bus.Byte_Data_i;
                            byte_idx == 2'd3: begin
                                // Top byte goes straight out with the finished word.
                                mem_data <= {bus.Byte_Data_i, asm_word};
                                mem_addr <= BASE_ADDRESS + (32'(word_idx) << 2);
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed bench for program_loader with a
// stream-level model of the expected memory writes.
module tb_program_loader;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic core_reset;
    logic busy;
    logic done;
    logic error;

    program_loader_if bus();

    program_loader #(
        .PROGRAM_MEMORY_DEPTH(DEPTH),
        .BASE_ADDRESS(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Start_i(start),
        .bus(bus),
        .Core_Reset_o(core_reset),
        .Busy_o(busy),
        .Done_o(done),
        .Error_o(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_acc = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] pa;
    logic [31:0] pd;
    bit prev_write = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Per-cycle compare against the expected write queue.
    always @(negedge clk) begin
        if (reset) begin
            chk("core_reset_eq_done", core_reset, done);
            if (bus.Byte_Ready_o) chk("ready_implies_busy", busy, 1);
            if (bus.Mem_Write_o) begin
                chk("write_ready_low", bus.Byte_Ready_o, 0);
                chk("write_busy", busy, 1);
                chk("write_single_cycle", prev_write, 0);
                if (exp_addr_q.size() == 0) begin
                    $display("FAIL unexpected_write: addr %h data %h",
                             bus.Mem_Address_o, bus.Mem_Data_o);
                    n_checks++;
                    n_fail++;
                end else begin
                    pa = exp_addr_q.pop_front();
                    pd = exp_data_q.pop_front();
                    chk("write_addr", bus.Mem_Address_o, pa);
                    chk("write_data", bus.Mem_Data_o, pd);
                end
                obs_addr.push_back(bus.Mem_Address_o);
                obs_data.push_back(bus.Mem_Data_o);
            end
            prev_write = bus.Mem_Write_o;
        end else begin
            prev_write = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            bus.Byte_Valid_i = 1'b0;
            @(negedge clk);
        end
        bus.Byte_Valid_i = 1'b1;
        bus.Byte_Data_i = b;
        t = 0;
        while (!bus.Byte_Ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.Byte_Ready_o) flag("accept_timeout");
        first_acc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] n, input logic [7:0] d[$],
                           input int gapmode, input bit pulse,
                           input int start_mid);
        logic [7:0] s[$];
        bit err;
        bit gap;
        int t;
        int acc0;
        err = (n == 16'd0) || (n > 16'(DEPTH));
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        if (!err) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_addr_q.push_back(BASE + 32'(4 * i));
                exp_data_q.push_back({d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
                for (int k = 0; k < 4; k++) s.push_back(d[4*i+k]);
            end
        end
        if (pulse) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        acc0 = 0;
        for (int i = 0; i < s.size(); i++) begin
            gap = (gapmode == 1) ? (i > 0) :
                  (gapmode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (i == start_mid) start = 1'b1;
            send_byte(s[i], gap);
            start = 1'b0;
            if (i == 0) acc0 = first_acc;
        end
        bus.Byte_Valid_i = 1'b0;
        t = 0;
        while (!(done || error) && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("end_done", done, !err);
        chk("end_error", error, err);
        chk("end_core_reset", core_reset, !err);
        chk("end_busy", busy, 0);
        chk("writes_outstanding", exp_addr_q.size(), 0);
        if (!err && gapmode == 0 && start_mid < 0)
            chk("load_cycles", cyc - acc0 + 1, 2 + 5 * int'(n));
    endtask

    logic [7:0] prog2[$];
    logic [7:0] rnd[$];
    int base_w;
    int nw;

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Byte_Valid_i = 1'b0;
        bus.Byte_Data_i = 8'h00;
        prog2 = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        repeat (2) @(negedge clk);
        chk("rst_addr", bus.Mem_Address_o, BASE);
        chk("rst_data", bus.Mem_Data_o, 0);
        chk("rst_ready", bus.Byte_Ready_o, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_core_reset", core_reset, 0);
        chk("idle_write", bus.Mem_Write_o, 0);

        // Reset mid-stream: no word completes, nothing written.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        bus.Byte_Valid_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ready", bus.Byte_Ready_o, 0);
        chk("mid_rst_write", bus.Mem_Write_o, 0);
        chk("mid_rst_addr", bus.Mem_Address_o, BASE);
        chk("mid_rst_data", bus.Mem_Data_o, 0);
        chk("mid_rst_status", {core_reset, busy, done, error}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_writes", obs_addr.size(), 0);

        // Two-word program, valid held high.
        do_load(16'd2, prog2, 0, 1, -1);
        chk("t2_count", obs_addr.size(), 2);
        chk("t2_addr0", obs_addr[0], 32'h0040_0000);
        chk("t2_data0", obs_data[0], 32'h00A0_0513);
        chk("t2_addr1", obs_addr[1], 32'h0040_0004);
        chk("t2_data1", obs_data[1], 32'h00B0_0593);

        // Same program with valid toggling.
        do_load(16'd2, prog2, 1, 1, -1);
        chk("t3_count", obs_addr.size(), 4);
        chk("t3_data1", obs_data[3], 32'h00B0_0593);

        // Illegal lengths, then a full-depth image.
        rnd.delete();
        do_load(16'd0, rnd, 0, 1, -1);
        do_load(16'h0041, rnd, 0, 1, -1);
        chk("err_no_writes", obs_addr.size(), 4);
        for (int i = 0; i < 4 * DEPTH; i++) rnd.push_back(8'($urandom));
        do_load(16'(DEPTH), rnd, 0, 1, -1);
        chk("full_count", obs_addr.size(), 4 + DEPTH);
        chk("full_last_addr", obs_addr[obs_addr.size()-1], 32'h0040_00FC);

        // Start during DATA is ignored.
        do_load(16'd2, prog2, 0, 1, 6);

        // Start in DONE drops core reset on the same edge.
        start = 1'b1;
        @(negedge clk);
        chk("restart_core_reset", core_reset, 0);
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        start = 1'b0;
        base_w = obs_addr.size();
        rnd.delete();
        for (int i = 0; i < 12; i++) rnd.push_back(8'($urandom));
        do_load(16'd3, rnd, 0, 0, -1);
        chk("restart_addr0", obs_addr[base_w], 32'h0040_0000);

        // Random loads, gaps and occasional bad lengths.
        for (int r = 0; r < 8; r++) begin
            nw = $urandom_range(1, 10);
            if ($urandom_range(0, 5) == 0) nw = DEPTH + $urandom_range(1, 3);
            rnd.delete();
            if (nw <= DEPTH)
                for (int i = 0; i < 4 * nw; i++) rnd.push_back(8'($urandom));
            do_load(16'(nw), rnd, 2, 1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
